// File: rtl/card_draw_scheduler.sv
// rtl/card_draw_scheduler.sv - queued 16x16 card fill scheduler driving a VGA pixel plotter
// Requests are buffered in a small FIFO and expanded into per-pixel writes over a 3x3 card grid.
module card_draw_scheduler #(
  parameter int GRID_X0    = 50,
  parameter int GRID_Y0    = 30,
  parameter int PITCH      = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_all,
  input  logic [3:0] req_card,
  input  logic [2:0] req_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             push, pop, fifo_empty;
  logic [7:0]       head;

  logic             cur_all;
  logic [3:0]       cur_card;
  logic [2:0]       cur_colour;
  logic [7:0]       x0_q;
  logic [6:0]       y0_q;
  logic [7:0]       pix_cnt, pix_next;
  logic             start_draw, next_card, pix_adv;

  assign req_ready  = (fifo_cnt != FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = req_valid && req_ready;
  assign head       = fifo_mem[rd_ptr];
  assign pix_next   = pix_cnt + 8'd1;

  assign writeEn = (state_q == DRAW);
  assign done    = (state_q == DONE);
  assign busy    = !fifo_empty || (state_q != IDLE);

  function automatic logic [7:0] card_x(input logic [3:0] card);
    case (card)
      4'd0, 4'd3, 4'd6: card_x = 8'(GRID_X0);
      4'd1, 4'd4, 4'd7: card_x = 8'(GRID_X0 + PITCH);
      default:          card_x = 8'(GRID_X0 + 2 * PITCH);
    endcase
  endfunction

  function automatic logic [6:0] card_y(input logic [3:0] card);
    case (card)
      4'd0, 4'd1, 4'd2: card_y = 7'(GRID_Y0);
      4'd3, 4'd4, 4'd5: card_y = 7'(GRID_Y0 + PITCH);
      default:          card_y = 7'(GRID_Y0 + 2 * PITCH);
    endcase
  endfunction

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_all, req_card, req_colour};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    err        = 1'b0;
    start_draw = 1'b0;
    next_card  = 1'b0;
    pix_adv    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!cur_all && (cur_card > 4'd8)) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          start_draw = 1'b1;
          state_d    = DRAW;
        end
      end
      DRAW: begin
        if (pix_cnt == 8'hFF) begin
          if (cur_all && (cur_card < 4'd8)) begin
            next_card = 1'b1;
            state_d   = LOAD;
          end else begin
            state_d = DONE;
          end
        end else begin
          pix_adv = 1'b1;
        end
      end
      DONE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // x/y/colour are registered so they hold the last pixel whenever writeEn is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_all    <= 1'b0;
      cur_card   <= '0;
      cur_colour <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      pix_cnt    <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
    end else begin
      if (pop) begin
        cur_all    <= head[7];
        cur_card   <= head[7] ? 4'd0 : head[6:3];
        cur_colour <= head[2:0];
      end
      if (next_card) cur_card <= cur_card + 4'd1;
      if (start_draw) begin
        pix_cnt <= '0;
        x0_q    <= card_x(cur_card);
        y0_q    <= card_y(cur_card);
        x       <= card_x(cur_card);
        y       <= card_y(cur_card);
        colour  <= cur_colour;
      end
      if (pix_adv) begin
        pix_cnt <= pix_next;
        x       <= x0_q + {4'b0000, pix_next[3:0]};
        y       <= y0_q + {3'b000, pix_next[7:4]};
      end
    end
  end

endmodule

// File: tb/tb_card_draw_scheduler.sv
// tb/tb_card_draw_scheduler.sv - self-checking bench for card_draw_scheduler
// A request-level model expands each accepted request into its expected per-cycle output stream.
module tb_card_draw_scheduler;

  localparam int GX = 50, GY = 30, P = 20, DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_all = 1'b0;
  logic [3:0] req_card = '0;
  logic [2:0] req_colour = '0;
  logic       req_ready, writeEn, busy, done, err;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  card_draw_scheduler #(.GRID_X0(GX), .GRID_Y0(GY), .PITCH(P), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_all(req_all), .req_card(req_card), .req_colour(req_colour),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we; int px; int py; int pc; logic dn; logic er; logic nopop; logic active;
  } rec_t;
  typedef struct { logic all; int card; int col; } req_t;

  req_t pending[$];
  rec_t plan[$];
  rec_t cur = '{default: 0};
  int   mx = 0, my = 0, mc = 0;
  logic last_nopop = 1'b0;
  logic m_acc = 1'b0;
  int   cyc = 0, m_acc_cyc = 0;
  int   nchk = 0, nerr = 0;

  // Each request becomes: LOAD, then per card 256 pixels (LOAD gap between cards), then DONE.
  function automatic void gen_plan(input req_t r);
    rec_t t, w;
    int first, last;
    t = '{default: 0};
    t.active = 1'b1;
    if (!r.all && r.card > 8) begin
      t.er = 1'b1;
      t.nopop = 1'b1;
      plan.push_back(t);
      return;
    end
    plan.push_back(t);
    first = r.all ? 0 : r.card;
    last  = r.all ? 8 : r.card;
    for (int k = first; k <= last; k++) begin
      if (k != first) plan.push_back(t);
      for (int p = 0; p < 256; p++) begin
        w = t;
        w.we = 1'b1;
        w.px = GX + P * (k % 3) + p % 16;
        w.py = GY + P * (k / 3) + p / 16;
        w.pc = r.col;
        plan.push_back(w);
      end
    end
    t.dn = 1'b1;
    plan.push_back(t);
  endfunction

  function automatic logic model_idle();
    return (pending.size() == 0) && (plan.size() == 0) && !cur.active;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    req_t nr;
    if (!reset_n) begin
      pending.delete();
      plan.delete();
      cur = '{default: 0};
      mx = 0; my = 0; mc = 0;
      last_nopop = 1'b0;
      m_acc = 1'b0;
    end else begin
      cyc++;
      m_acc = req_valid && (pending.size() < DEPTH);
      if (plan.size() == 0 && !last_nopop && pending.size() > 0) gen_plan(pending.pop_front());
      if (plan.size() > 0) cur = plan.pop_front();
      else cur = '{default: 0};
      if (m_acc) begin
        nr.all = req_all; nr.card = int'(req_card); nr.col = int'(req_colour);
        pending.push_back(nr);
        m_acc_cyc = cyc;
      end
      last_nopop = cur.nopop;
      if (cur.we) begin mx = cur.px; my = cur.py; mc = cur.pc; end
    end
  end

  always @(negedge clk) begin
    logic e_rdy, e_busy;
    e_rdy  = pending.size() < DEPTH;
    e_busy = (pending.size() > 0) || cur.active;
    nchk++;
    if (writeEn !== cur.we || x !== 8'(mx) || y !== 7'(my) || colour !== 3'(mc) ||
        done !== cur.dn || err !== cur.er || busy !== e_busy || req_ready !== e_rdy) begin
      nerr++;
      $display("FAIL cycle %0d: dut we=%b x=%0d y=%0d col=%0d done=%b err=%b busy=%b rdy=%b; model we=%b x=%0d y=%0d col=%0d done=%b err=%b busy=%b rdy=%b",
               cyc, writeEn, x, y, colour, done, err, busy, req_ready,
               cur.we, mx, my, mc, cur.dn, cur.er, e_busy, e_rdy);
    end
  end

  int mon_writes = 0, mon_dones = 0, mon_errs = 0, mon_first_cyc = 0, mon_done_cyc = 0;
  int fx = 0, fy = 0, lx = 0, ly = 0, rises = 0, gap_total = 0, zero_run = 0;

  always @(negedge clk) begin
    if (done) begin mon_dones++; mon_done_cyc = cyc; end
    if (err) mon_errs++;
    if (writeEn) begin
      if (mon_writes == 0) begin
        mon_first_cyc = cyc; fx = x; fy = y;
      end else if (zero_run > 0) begin
        gap_total += zero_run; rises++;
      end
      lx = x; ly = y;
      mon_writes++;
      zero_run = 0;
    end else begin
      zero_run++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    mon_writes = 0; mon_dones = 0; mon_errs = 0; mon_first_cyc = 0; mon_done_cyc = 0;
    fx = 0; fy = 0; lx = 0; ly = 0; rises = 0; gap_total = 0; zero_run = 0;
    @(negedge clk);
  endtask

  task automatic send(input logic a, input int c, input int col, input int budget);
    logic ok;
    ok = 1'b0;
    req_valid = 1'b1; req_all = a; req_card = 4'(c); req_colour = 3'(col);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_acc) begin ok = 1'b1; break; end
    end
    req_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int n, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (mon_dones >= n) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    if (!ok) chk("done_timeout", mon_dones, n);
  endtask

  task automatic wait_idle(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (model_idle()) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    logic ok;
    repeat (3) @(negedge clk);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_we", writeEn, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);

    clear_mon();
    send(1'b0, 4, 7, 10);
    a = m_acc_cyc;
    wait_done(1, 400);
    wait_idle(10);
    chk("single_writes", mon_writes, 256);
    chk("single_first_cycle", mon_first_cyc, a + 2);
    chk("single_done_cycle", mon_done_cyc, a + 258);
    chk("single_first_x", fx, 70);
    chk("single_first_y", fy, 50);
    chk("single_last_x", lx, 85);
    chk("single_last_y", ly, 65);
    chk("single_colour", colour, 7);

    clear_mon();
    send(1'b1, 0, 2, 10);
    wait_done(1, 2400);
    wait_idle(10);
    chk("grid_writes", mon_writes, 2304);
    chk("grid_first_x", fx, 50);
    chk("grid_first_y", fy, 30);
    chk("grid_last_x", lx, 105);
    chk("grid_last_y", ly, 85);
    chk("grid_dones", mon_dones, 1);
    chk("grid_gaps", rises, 8);
    chk("grid_gap_cycles", gap_total, 8);

    clear_mon();
    send(1'b0, 9, 3, 10);
    repeat (5) @(negedge clk);
    chk("inv_errs", mon_errs, 1);
    chk("inv_writes", mon_writes, 0);
    chk("inv_dones", mon_dones, 0);
    send(1'b0, 0, 5, 10);
    wait_done(1, 400);
    wait_idle(10);
    chk("after_inv_writes", mon_writes, 256);
    chk("after_inv_x", fx, 50);
    chk("after_inv_errs", mon_errs, 1);

    clear_mon();
    send(1'b1, 0, 1, 10);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) send(1'b0, k, k + 2, 10);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_busy", busy, 1);
    send(1'b0, 4, 6, 3000);
    send(1'b0, 5, 7, 3000);
    wait_done(7, 5000);
    wait_idle(10);
    chk("bp_dones", mon_dones, 7);
    chk("bp_writes", mon_writes, 2304 + 6 * 256);

    clear_mon();
    send(1'b1, 0, 4, 10);
    send(1'b0, 1, 1, 10);
    send(1'b0, 2, 2, 10);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (mon_writes >= 612) begin ok = 1'b1; break; end
    end
    if (!ok) chk("rst_mid_timeout", mon_writes, 612);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_we", writeEn, 0);
    chk("mid_rst_x", x, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_colour", colour, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    clear_mon();
    repeat (300) @(negedge clk);
    chk("post_rst_writes", mon_writes, 0);
    chk("post_rst_dones", mon_dones, 0);
    chk("post_rst_busy", busy, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req_valid && m_acc) req_valid = 1'b0;
      if (!req_valid && $urandom_range(0, 9) == 0) begin
        req_all    = ($urandom_range(0, 19) == 0);
        req_card   = 4'($urandom_range(0, 10));
        req_colour = 3'($urandom_range(0, 7));
        req_valid  = 1'b1;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle(25000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
